// File: rtl/la_capture_ctrl.sv
// la_capture_ctrl: trigger/capture sequencer for the logic analyzer sample RAM.
// Rev 1.0 - initial release.
`default_nettype none

module la_capture_ctrl #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [DW-1:0] MONITOR_SIGNAL,
  input  logic          step_en,
  input  logic          stop_n,
  input  logic          arm,
  input  logic [DW-1:0] trig_mask,
  input  logic [DW-1:0] trig_value,
  input  logic [AW-1:0] post_count,
  output logic          la_we,
  output logic [AW-1:0] WA,
  output logic [AW-1:0] trig_addr,
  output logic          wrapped,
  output logic          busy,
  output logic          done,
  output logic [7:0]    STATUS
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARMED = 3'd1;
  localparam logic [2:0] S_POST  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;

  logic [2:0]    r_state;
  logic [AW-1:0] r_wa;
  logic [AW-1:0] r_trig_addr;
  logic [AW-1:0] r_remaining;
  logic          r_wrapped;
  logic          r_trig_seen;

  logic          w_active;
  logic          w_we;
  logic          w_hit;
  logic          w_wa_top;

  assign w_active = (r_state == S_ARMED) || (r_state == S_POST);
  assign w_we     = step_en & stop_n & w_active;
  assign w_hit    = ((MONITOR_SIGNAL & trig_mask) == (trig_value & trig_mask));
  assign w_wa_top = &r_wa;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_wa        <= '0;
      r_trig_addr <= '0;
      r_remaining <= '0;
      r_wrapped   <= 1'b0;
      r_trig_seen <= 1'b0;
    end else if (!stop_n) begin
      // Abort keeps the pointers so the partial window stays inspectable.
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            r_state     <= S_ARMED;
            r_wa        <= '0;
            r_trig_addr <= '0;
            r_wrapped   <= 1'b0;
            r_trig_seen <= 1'b0;
            r_remaining <= post_count;
          end
        end
        S_ARMED: begin
          if (w_we) begin
            r_wa <= r_wa + 1'b1;
            if (w_wa_top) r_wrapped <= 1'b1;
            if (w_hit) begin
              r_trig_addr <= r_wa;
              r_trig_seen <= 1'b1;
              r_state     <= (r_remaining == '0) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          if (w_we) begin
            r_wa        <= r_wa + 1'b1;
            r_remaining <= r_remaining - 1'b1;
            if (w_wa_top) r_wrapped <= 1'b1;
            if (r_remaining == {{(AW-1){1'b0}}, 1'b1}) r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign la_we     = w_we;
  assign WA        = r_wa;
  assign trig_addr = r_trig_addr;
  assign wrapped   = r_wrapped;
  assign busy      = w_active;
  assign done      = (r_state == S_DONE);
  assign STATUS    = {r_state, r_wrapped, r_trig_seen, 3'b000};

endmodule

`default_nettype wire

// File: tb/tb_la_capture_ctrl.sv
// tb_la_capture_ctrl: scoreboard bench for la_capture_ctrl.
// Rev 1.0 - initial release.
`default_nettype none

module tb_la_capture_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] mon;
  logic        step_en;
  logic        stop_n;
  logic        arm;
  logic [31:0] trig_mask;
  logic [31:0] trig_value;
  logic [4:0]  post_count;
  logic        la_we;
  logic [4:0]  wa;
  logic [4:0]  trig_addr;
  logic        wrapped;
  logic        busy;
  logic        done;
  logic [7:0]  status;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];

  la_capture_ctrl #(.AW(5), .DW(32)) u_dut (
    .CLK            (clk),
    .RESET          (rst_n),
    .MONITOR_SIGNAL (mon),
    .step_en        (step_en),
    .stop_n         (stop_n),
    .arm            (arm),
    .trig_mask      (trig_mask),
    .trig_value     (trig_value),
    .post_count     (post_count),
    .la_we          (la_we),
    .WA             (wa),
    .trig_addr      (trig_addr),
    .wrapped        (wrapped),
    .busy           (busy),
    .done           (done),
    .STATUS         (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock of stimulus; expected write address goes to the scoreboard.
  task automatic step(input logic se, input logic [31:0] d, input logic exp_we, input logic [4:0] exp_a);
    logic [4:0] a;
    step_en = se;
    mon     = d;
    if (exp_we) exp_q.push_back(exp_a);
    @(negedge clk);
    check_eq("la_we", {31'd0, la_we}, {31'd0, exp_we});
    if (la_we) begin
      if (exp_q.size() > 0) begin
        a = exp_q.pop_front();
        check_eq("wr_addr", {27'd0, wa}, {27'd0, a});
      end else begin
        check_eq("wr_unexpected", exp_q.size(), 1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [31:0] m, input logic [31:0] v, input logic [4:0] pc);
    trig_mask  = m;
    trig_value = v;
    post_count = pc;
    step_en    = 1'b0;
    arm        = 1'b1;
    @(posedge clk);
    #1;
    arm = 1'b0;
    check_eq("arm_busy", {31'd0, busy}, 32'd1);
    check_eq("arm_wa", {27'd0, wa}, 32'd0);
  endtask

  task automatic run_window(input bit toggle);
    do_arm(32'h0000_00FF, 32'h0000_00A5, 5'd3);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h5500_0000 | i, 1'b1, 5'(i));
      if (toggle) step(1'b0, 32'h0000_00A5, 1'b0, 5'd0);
    end
    step(1'b1, 32'h1234_56A5, 1'b1, 5'd10);
    check_eq("trig_addr", {27'd0, trig_addr}, 32'd10);
    check_eq("post_status", {24'd0, status}, 32'h48);
    if (toggle) step(1'b0, 32'h0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("not_done_yet", {31'd0, done}, 32'd0);
      step(1'b1, 32'hABCD_0000 | i, 1'b1, 5'(11 + i));
      if (toggle) step(1'b0, 32'h0, 1'b0, 5'd0);
    end
    check_eq("done", {31'd0, done}, 32'd1);
    check_eq("done_wa", {27'd0, wa}, 32'd14);
    check_eq("done_status", {24'd0, status}, 32'h68);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_00A5, 1'b0, 5'd0);
    check_eq("done_hold", {31'd0, done}, 32'd1);
    check_eq("done_hold_wa", {27'd0, wa}, 32'd14);
  endtask

  initial begin
    rst_n      = 1'b0;
    mon        = '0;
    step_en    = 1'b0;
    stop_n     = 1'b1;
    arm        = 1'b0;
    trig_mask  = '0;
    trig_value = '0;
    post_count = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_status", {24'd0, status}, 32'h00);
    check_eq("rst_wa", {27'd0, wa}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    step(1'b1, 32'h0, 1'b0, 5'd0);

    // Continuous and half-rate stepping over the same window
    run_window(1'b0);
    run_window(1'b1);

    // Wrap before trigger, zero post samples
    do_arm(32'h0000_00FF, 32'h0000_00A5, 5'd0);
    for (int i = 0; i < 40; i++) step(1'b1, 32'h7700_0000 | i, 1'b1, 5'(i % 32));
    step(1'b1, 32'h0000_00A5, 1'b1, 5'd8);
    check_eq("wrap_done", {31'd0, done}, 32'd1);
    check_eq("wrap_wa", {27'd0, wa}, 32'd9);
    check_eq("wrap_trig_addr", {27'd0, trig_addr}, 32'd8);
    check_eq("wrap_flag", {31'd0, wrapped}, 32'd1);
    check_eq("wrap_status", {24'd0, status}, 32'h78);

    // Trigger on the sample that wraps the pointer
    do_arm(32'h0000_00FF, 32'h0000_00A5, 5'd0);
    for (int i = 0; i < 31; i++) step(1'b1, 32'h0000_0100 | i, 1'b1, 5'(i));
    step(1'b1, 32'h0000_00A5, 1'b1, 5'd31);
    check_eq("wtrig_addr", {27'd0, trig_addr}, 32'd31);
    check_eq("wtrig_wrapped", {31'd0, wrapped}, 32'd1);
    check_eq("wtrig_wa", {27'd0, wa}, 32'd0);

    // Abort during ARMED
    do_arm(32'h0000_00FF, 32'h0000_00A5, 5'd3);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0010 | i, 1'b1, 5'(i));
    stop_n = 1'b0;
    step(1'b1, 32'h0000_0001, 1'b0, 5'd0);
    stop_n = 1'b1;
    check_eq("stop_status", {24'd0, status}, 32'h00);
    check_eq("stop_wa", {27'd0, wa}, 32'd3);
    step(1'b1, 32'h0000_00A5, 1'b0, 5'd0);
    do_arm(32'h0000_00FF, 32'h0000_00A5, 5'd3);
    step(1'b1, 32'h0000_0002, 1'b1, 5'd0);

    // Zero mask: first sample triggers; arm in POST is ignored
    stop_n = 1'b0;
    step(1'b0, 32'h0, 1'b0, 5'd0);
    stop_n = 1'b1;
    do_arm(32'h0, 32'hFFFF_FFFF, 5'd3);
    step(1'b1, 32'h1111_1111, 1'b1, 5'd0);
    check_eq("m0_trig_addr", {27'd0, trig_addr}, 32'd0);
    arm = 1'b1;
    step(1'b1, 32'h2222_2222, 1'b1, 5'd1);
    arm = 1'b0;
    step(1'b1, 32'h3333_3333, 1'b1, 5'd2);
    step(1'b1, 32'h4444_4444, 1'b1, 5'd3);
    check_eq("m0_done", {31'd0, done}, 32'd1);
    check_eq("m0_wa", {27'd0, wa}, 32'd4);

    // Reset in the middle of POST
    do_arm(32'h0000_00FF, 32'h0000_00A5, 5'd5);
    step(1'b1, 32'h0000_0001, 1'b1, 5'd0);
    step(1'b1, 32'h0000_0002, 1'b1, 5'd1);
    step(1'b1, 32'h0000_00A5, 1'b1, 5'd2);
    step(1'b1, 32'h0000_0003, 1'b1, 5'd3);
    check_eq("pre_rst_status", {24'd0, status}, 32'h48);
    rst_n = 1'b0;
    step(1'b0, 32'h0, 1'b0, 5'd0);
    rst_n = 1'b1;
    check_eq("mid_rst_status", {24'd0, status}, 32'h00);
    check_eq("mid_rst_wa", {27'd0, wa}, 32'd0);
    check_eq("mid_rst_trig_addr", {27'd0, trig_addr}, 32'd0);
    step(1'b1, 32'h0000_00A5, 1'b0, 5'd0);

    check_eq("q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
